// File: rtl/tmr_pkg.sv
// Shared definitions for the triple-modular-redundancy voter: FSM encoding,
// lane indices and a lane-to-one-hot helper.
package tmr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESYNC = 2'd1,
        ST_CHECK  = 2'd2
    } tmr_state_e;

    localparam int LANE_A    = 0;
    localparam int LANE_B    = 1;
    localparam int LANE_C    = 2;
    localparam int NUM_LANES = 3;
    localparam int CONSEC_W  = 4;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/tmr_lane_mon.sv
// Per-lane health monitor: saturating total-error counter plus a
// consecutive-mismatch counter that flags when a resync is due.
module tmr_lane_mon
    import tmr_pkg::*;
#(
    parameter int ERR_THRESH = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             mismatch,
    input  logic             match,
    input  logic             clr_consec,
    output logic [CNT_W-1:0] err_cnt,
    output logic             at_thresh
);

    localparam logic [CONSEC_W-1:0] THRESH = CONSEC_W'(ERR_THRESH);

    logic [CNT_W-1:0]    err_q, err_d;
    logic [CONSEC_W-1:0] con_q, con_d;

    always_comb begin
        err_d = err_q;
        con_d = con_q;
        if (mismatch && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end
        // A lane at threshold stays pending until the controller services it.
        if (con_q != THRESH) begin
            if (mismatch) begin
                con_d = con_q + 4'd1;
            end else if (match) begin
                con_d = '0;
            end
        end
        if (clr_consec) begin
            con_d = '0;
        end
        if (clr) begin
            err_d = '0;
            con_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
            con_q <= '0;
        end else begin
            err_q <= err_d;
            con_q <= con_d;
        end
    end

    assign err_cnt   = err_q;
    assign at_thresh = (con_q == THRESH);

endmodule

// File: rtl/tmr_vote_ctrl.sv
// TMR voter with per-lane error tracking and a resync controller that
// reloads a misbehaving replica and disables it if it stays wrong.
module tmr_vote_ctrl
    import tmr_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int ERR_THRESH    = 3,
    parameter int RESYNC_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       resync_req,
    output logic             resync_busy,
    output logic [2:0]       fault,
    output logic             uncorrectable,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c
);

    localparam logic [7:0] RC_LAST = 8'(RESYNC_CYCLES - 1);

    tmr_state_e       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic [2:0]       fault_q, fault_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             uncorr_q, uncorr_d;

    logic [2:0][WIDTH-1:0] lanes;
    logic [2:0][CNT_W-1:0] err_cnt;
    logic [2:0]            excl, mismatch, match, at_thresh, ready, clr_consec;
    logic [1:0]            n_excl;
    logic [WIDTH-1:0]      maj, first_ok, voted, sel_lane;
    logic                  uncorr_c;

    assign lanes = {inC, inB, inA};

    // The lane under resync is treated exactly like a faulted lane.
    always_comb begin
        excl   = fault_q | ((state_q != ST_IDLE) ? lane_onehot(sel_q) : 3'b000);
        n_excl = {1'b0, excl[0]} + {1'b0, excl[1]} + {1'b0, excl[2]};
    end

    always_comb begin
        maj      = (inA & inB) | (inA & inC) | (inB & inC);
        first_ok = inA;
        if (!excl[LANE_A]) begin
            first_ok = inA;
        end else if (!excl[LANE_B]) begin
            first_ok = inB;
        end else if (!excl[LANE_C]) begin
            first_ok = inC;
        end
        voted    = first_ok;
        uncorr_c = 1'b1;
        case (n_excl)
            2'd0: begin
                voted    = maj;
                uncorr_c = (inA != inB) && (inA != inC) && (inB != inC);
            end
            2'd1: begin
                uncorr_c = excl[LANE_A] ? (inB != inC) :
                           excl[LANE_B] ? (inA != inC) : (inA != inB);
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            mismatch[i] = in_valid && !excl[i] && (lanes[i] != voted);
            match[i]    = in_valid && !excl[i] && (lanes[i] == voted);
        end
        ready = at_thresh & ~fault_q;
        case (sel_q)
            2'd0:    sel_lane = inA;
            2'd1:    sel_lane = inB;
            default: sel_lane = inC;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rcnt_d     = rcnt_q;
        fault_d    = fault_q;
        clr_consec = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (|ready) begin
                    sel_d      = ready[0] ? 2'd0 : (ready[1] ? 2'd1 : 2'd2);
                    clr_consec = lane_onehot(sel_d);
                    rcnt_d     = '0;
                    state_d    = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                if (rcnt_q == RC_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (in_valid) begin
                    if (sel_lane != voted) begin
                        fault_d = fault_q | lane_onehot(sel_q);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_IDLE;
            fault_d = '0;
            rcnt_d  = '0;
        end
    end

    always_comb begin
        out_data_d = in_valid ? voted : out_data_q;
        uncorr_d   = in_valid && uncorr_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            rcnt_q      <= '0;
            fault_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            uncorr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rcnt_q      <= rcnt_d;
            fault_q     <= fault_d;
            out_valid_q <= in_valid;
            out_data_q  <= out_data_d;
            uncorr_q    <= uncorr_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_mon
        tmr_lane_mon #(
            .ERR_THRESH(ERR_THRESH),
            .CNT_W     (CNT_W)
        ) u_mon (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .mismatch  (mismatch[g]),
            .match     (match[g]),
            .clr_consec(clr_consec[g]),
            .err_cnt   (err_cnt[g]),
            .at_thresh (at_thresh[g])
        );
    end

    // Decoded from state flops so an asynchronous reset drops it at once.
    assign resync_req    = (state_q == ST_RESYNC) ? lane_onehot(sel_q) : 3'b000;
    assign resync_busy   = (state_q != ST_IDLE);
    assign fault         = fault_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign uncorrectable = uncorr_q;
    assign err_cnt_a     = err_cnt[LANE_A];
    assign err_cnt_b     = err_cnt[LANE_B];
    assign err_cnt_c     = err_cnt[LANE_C];

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Bench for tmr_vote_ctrl: directed scenarios plus random traffic, checked
// against a lane-level behavioural model and an output scoreboard.
module tb_tmr_vote_ctrl;

    localparam int WIDTH   = 16;
    localparam int T       = 3;
    localparam int RC      = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst, in_valid, clr;
    logic [WIDTH-1:0] inA, inB, inC;
    logic             out_valid, resync_busy, uncorrectable;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       resync_req, fault;
    logic [CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

    always #5 clk = ~clk;

    tmr_vote_ctrl #(
        .WIDTH(WIDTH), .ERR_THRESH(T), .RESYNC_CYCLES(RC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .inA(inA), .inB(inB), .inC(inC), .clr(clr),
        .out_valid(out_valid), .out_data(out_data),
        .resync_req(resync_req), .resync_busy(resync_busy),
        .fault(fault), .uncorrectable(uncorrectable),
        .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH:0] exp_q[$];  // {uncorrectable, out_data}

    // Model: lane status after the most recent clock edge.
    bit m_fault[3];
    int m_err[3];
    int m_con[3];
    int m_busy;   // lane being serviced, -1 when none
    int m_left;   // reload cycles still to go; 0 while awaiting the verdict

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_fault[i] = 0;
            m_err[i]   = 0;
            m_con[i]   = 0;
        end
        m_busy = -1;
        m_left = 0;
    endtask

    task automatic model_step(input bit v, input logic [WIDTH-1:0] a, b, c, input bit cl);
        logic [WIDTH-1:0] ln[3];
        logic [WIDTH-1:0] hv[$];
        logic [WIDTH-1:0] voted;
        bit               ex[3];
        bit               mis[3];
        bit               unc;
        int               healthy, ones, pick;
        ln = '{a, b, c};
        healthy = 0;
        for (int i = 0; i < 3; i++) begin
            ex[i] = m_fault[i] || (m_busy == i);
            if (!ex[i]) begin
                healthy++;
                hv.push_back(ln[i]);
            end
        end
        if (healthy == 3) begin
            for (int j = 0; j < WIDTH; j++) begin
                ones = int'(a[j]) + int'(b[j]) + int'(c[j]);
                voted[j] = (ones >= 2);
            end
            unc = (a != b) && (b != c) && (a != c);
        end else begin
            voted = a;
            for (int i = 2; i >= 0; i--) if (!ex[i]) voted = ln[i];
            unc = (healthy == 2) ? (hv[0] != hv[1]) : 1'b1;
        end
        if (v) exp_q.push_back({unc, voted});
        for (int i = 0; i < 3; i++) mis[i] = v && !ex[i] && (ln[i] != voted);
        if (cl) begin
            model_reset();
            return;
        end
        pick = -1;
        if (m_busy < 0) begin
            for (int i = 2; i >= 0; i--) if (m_con[i] == T && !m_fault[i]) pick = i;
        end else if (m_left > 0) begin
            m_left--;
        end else if (v) begin
            if (ln[m_busy] != voted) m_fault[m_busy] = 1;
            m_busy = -1;
        end
        for (int i = 0; i < 3; i++) begin
            if (mis[i] && m_err[i] < CNT_MAX) m_err[i]++;
            if (i == pick) m_con[i] = 0;
            else if (m_con[i] == T) m_con[i] = T;
            else if (mis[i]) m_con[i]++;
            else if (v && !ex[i]) m_con[i] = 0;
        end
        if (pick >= 0) begin
            m_busy = pick;
            m_left = RC;
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_regs();
        logic [2:0] e_req, e_fault;
        e_req   = (m_busy >= 0 && m_left > 0) ? 3'(1 << m_busy) : 3'b000;
        e_fault = {m_fault[2], m_fault[1], m_fault[0]};
        check_val("status{req,busy,fault,ea,eb,ec}",
                  {resync_req, resync_busy, fault, err_cnt_a, err_cnt_b, err_cnt_c},
                  {e_req, (m_busy >= 0), e_fault, 8'(m_err[0]), 8'(m_err[1]), 8'(m_err[2])});
    endtask

    task automatic cycle(input bit v, input logic [WIDTH-1:0] a, b, c, input bit cl);
        @(negedge clk);
        check_regs();
        in_valid = v;
        inA = a;
        inB = b;
        inC = c;
        clr = cl;
        model_step(v, a, b, c, cl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0);
    endtask

    // Scoreboard monitor: every presented output consumes one expectation.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (!rst) begin
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_unexpected got=%h exp=none t=%0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({uncorrectable, out_data} !== e) begin
                        n_bad++;
                        $display("FAIL vote{unc,data} got=%h exp=%h t=%0t",
                                 {uncorrectable, out_data}, e, $time);
                    end
                end
            end else begin
                n_cmp++;
                if (uncorrectable !== 1'b0) begin
                    n_bad++;
                    $display("FAIL unc_idle got=%b exp=0 t=%0t", uncorrectable, $time);
                end
            end
        end
    end

    initial begin
        int seen, last_a, first_c, cnt_a, cnt_c, bad_lane, guard;
        logic [WIDTH-1:0] base, ln[3];
        rst = 1'b1; in_valid = 1'b0; clr = 1'b0; inA = '0; inB = '0; inC = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Unanimous sample.
        cycle(1'b1, 16'h1234, 16'h1234, 16'h1234, 1'b0);
        idle(2);

        // Lane B wrong three times, reload, then agrees during the check.
        repeat (3) cycle(1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            if (resync_req == 3'b010) seen++;
        end
        check_val("resync_b_cycles", 64'(seen), 64'd4);
        check_val("err_b_after_3", 64'(err_cnt_b), 64'd3);
        check_val("busy_in_check", 64'(resync_busy), 64'd1);
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        idle(1);
        check_val("fault_after_good_check", 64'({fault, resync_busy}), 64'd0);

        // Lane B still wrong during the check: it becomes faulted.
        repeat (3) cycle(1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
        idle(8);
        cycle(1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
        cycle(1'b1, 16'h0001, 16'hAAAA, 16'h0002, 1'b0);
        idle(1);
        check_val("fault_b_set", 64'(fault), 64'b010);
        check_val("err_b_after_6", 64'(err_cnt_b), 64'd6);
        cycle(1'b0, '0, '0, '0, 1'b1);
        idle(1);

        // A and C reach threshold together: A first, C right after.
        repeat (3) cycle(1'b1, 16'h0001, 16'h0000, 16'h0002, 1'b0);
        last_a = -1; first_c = -1; cnt_a = 0; cnt_c = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, 16'h5555, 16'h5555, 16'h5555, 1'b0);
            if (resync_req == 3'b001) begin last_a = k; cnt_a++; end
            if (resync_req == 3'b100) begin if (first_c < 0) first_c = k; cnt_c++; end
        end
        check_val("resync_a_cycles", 64'(cnt_a), 64'd4);
        check_val("resync_c_cycles", 64'(cnt_c), 64'd4);
        check_val("c_follows_a_gap", 64'(first_c - last_a), 64'd3);
        idle(2);

        // Long run of B errors: total counter must saturate.
        cycle(1'b0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 800; k++) begin
            if (m_busy == 1 && m_left == 0)
                cycle(1'b1, 16'h00F0, 16'h00F0, 16'h00F0, 1'b0);
            else
                cycle(1'b1, 16'h00F0, 16'h0F00, 16'h00F0, 1'b0);
        end
        idle(8);
        check_val("err_b_saturated", 64'(err_cnt_b), 64'(CNT_MAX));
        cycle(1'b0, '0, '0, '0, 1'b1);

        // Random traffic with a periodically chosen misbehaving lane.
        bad_lane = 3;
        for (int k = 0; k < 1500; k++) begin
            if (k % 40 == 0) bad_lane = $urandom_range(0, 3);
            base = WIDTH'($urandom);
            for (int i = 0; i < 3; i++) begin
                ln[i] = base;
                if ($urandom_range(0, 9) == 0) ln[i] = WIDTH'($urandom);
                if (i == bad_lane && $urandom_range(0, 9) < 7) ln[i] = base ^ WIDTH'($urandom_range(1, 65535));
            end
            cycle($urandom_range(0, 3) != 0, ln[0], ln[1], ln[2], $urandom_range(0, 199) == 0);
        end
        idle(2);

        // Asynchronous reset in the middle of a reload.
        cycle(1'b0, '0, '0, '0, 1'b1);
        repeat (3) cycle(1'b1, 16'h0F0F, 16'h0000, 16'h0F0F, 1'b0);
        guard = 0;
        while (resync_req == 3'b000 && guard < 10) begin
            idle(1);
            guard++;
        end
        check_val("reached_resync", 64'(resync_req), 64'b010);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_req", 64'(resync_req), 64'd0);
        check_val("async_rst_all",
                  {15'd0, out_valid, out_data, uncorrectable, resync_req, resync_busy,
                   fault, err_cnt_a, err_cnt_b, err_cnt_c}, 64'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b0);
        idle(3);

        check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tmr_vote_ctrl.md
TMR_VOTE_CTRL -- requirements
Module: tmr_vote_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, width of each replica data lane.
REQ-002 SHALL have parameter ERR_THRESH, default 3, consecutive mismatches before a lane is resynced (range 1..15).
REQ-003 SHALL have parameter RESYNC_CYCLES, default 4, length of the resync pulse (range 1..255).
REQ-004 SHALL have parameter CNT_W, default 8, width of the total-error counters.
REQ-005 SHALL have ports: clk input 1 (sole clock); rst input 1 (asynchronous, active-high reset).
REQ-006 SHALL have ports: in_valid input 1 (sample qualifier); inA, inB, inC input WIDTH (replica outputs).
REQ-007 SHALL have ports: clr input 1 (synchronous clear of counters and faults); out_valid output 1; out_data output WIDTH (voted data).
REQ-008 SHALL have ports: resync_req output 3 (one-hot, bit0=A, bit1=B, bit2=C, reload request to the replica); resync_busy output 1.
REQ-009 SHALL have ports: fault output 3 (sticky lane-disabled flags); uncorrectable output 1 (pulse); err_cnt_a, err_cnt_b, err_cnt_c output CNT_W.

Function
REQ-010 SHALL register out_data and out_valid with 1-cycle latency from in_valid; out_valid = in_valid delayed by one cycle.
REQ-011 Zero faulted lanes: out_data SHALL be the bitwise majority of inA, inB and inC.
REQ-012 One faulted lane: out_data SHALL be the lower-index healthy lane. If the two healthy lanes differ, uncorrectable SHALL pulse for one cycle, aligned with out_valid.
REQ-013 Two or more faulted lanes: out_data SHALL be the lowest-index healthy lane, or inA if all lanes are faulted. uncorrectable SHALL pulse on every valid sample.
REQ-014 Zero faults and all three lanes pairwise distinct: uncorrectable SHALL pulse, and out_data remains the bitwise majority.
REQ-015 A healthy lane mismatches when in_valid=1 and lane != voted value. Faulted lanes SHALL NOT be compared and SHALL NOT count.
REQ-016 Each mismatch SHALL increment that lane's err_cnt, saturating at 2^CNT_W-1.
REQ-017 Each lane SHALL have a consecutive-mismatch counter: increment on mismatch, clear on a valid match, hold when in_valid=0.
REQ-018 FSM states SHALL be IDLE, RESYNC and CHECK.
REQ-019 IDLE->RESYNC SHALL occur when any lane's consecutive count reaches ERR_THRESH. If lanes reach it simultaneously, the lowest index is selected. The selected lane's consecutive counter is then cleared.
REQ-020 In RESYNC, resync_req[selected] SHALL be high for exactly RESYNC_CYCLES cycles, then the FSM moves to CHECK.
REQ-021 In CHECK, the FSM SHALL wait for the next in_valid. If the selected lane matches, go to IDLE; if not, set fault[selected] and go to IDLE.
REQ-022 resync_busy SHALL be 1 in RESYNC and CHECK. Other lanes reaching threshold meanwhile SHALL hold their count saturated at ERR_THRESH and be serviced after return to IDLE.
REQ-023 During RESYNC and CHECK, the selected lane SHALL be excluded from voting and counting, and voted as if faulted.
REQ-024 clr SHALL zero all err_cnt, consecutive counters and fault, and force the FSM to IDLE (resync_req=0). Datapath output is unaffected. clr has priority over concurrent increments.

Reset
REQ-025 rst SHALL asynchronously force out_valid=0, out_data=0, uncorrectable=0, resync_req=0, resync_busy=0, fault=0, all counters=0, FSM=IDLE.
REQ-026 rst asserted mid-RESYNC SHALL deassert resync_req immediately, without waiting for clk.

Structure
REQ-027 FSM state encoding and lane index constants (LANE_A=0, LANE_B=1, LANE_C=2) SHALL reside in shared package tmr_pkg.
REQ-028 The per-lane error/consecutive counter logic SHALL be one sub-module, tmr_lane_mon, instantiated three times.

Verification
REQ-029 inA=inB=inC=0x1234 with in_valid -> out_data=0x1234 one cycle later; no counts, no uncorrectable.
REQ-030 inB=0x0000, inA=inC=0xFFFF for 3 valid cycles -> err_cnt_b=3; resync_req=3'b010 for 4 cycles; next matching sample -> IDLE, fault=0.
REQ-031 Same as REQ-030 but B still mismatching in CHECK -> fault=3'b010. Then inA=1, inC=2 -> out_data=1 and an uncorrectable pulse.
REQ-032 A and C both reach threshold on the same cycle -> A resynced first; C resync_req follows immediately after A's CHECK completes.
REQ-033 rst asserted during RESYNC -> resync_req=0 with no clock edge; all outputs at reset values. Also: 300 B mismatches with CNT_W=8 -> err_cnt_b saturates at 255.
